// File: rtl/platform_landing_detect.sv
// Per-frame landing detector: scans N_PLAT snapshotted platforms, picks the nearest hit, emits scroll distance and score.
// Optional macro PLAT_OVERRUN_CNT_EN adds an 8-bit saturating count of frame ticks dropped while busy.
module platform_landing_detect #(
    parameter int N_PLAT      = 8,
    parameter int PLAT_HALF_W = 20,
    parameter int DOODLE_HALF = 8,
    parameter int SCROLL_LINE = 120,
    parameter int MAX_SCROLL  = 15,
    parameter int SCREEN_H    = 240
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  frame_clk,
    input  logic [9:0]            Doodle_X,
    input  logic [9:0]            Doodle_Y,
    input  logic [9:0]            Doodle_Y_vel,
    input  logic [10*N_PLAT-1:0]  Plat_X_all,
    input  logic [10*N_PLAT-1:0]  Plat_Y_all,
    output logic                  land_pulse,
    output logic [2:0]            land_idx,
    output logic [9:0]            distance,
    output logic                  scroll_valid,
    output logic                  busy,
    output logic [15:0]           score
`ifdef PLAT_OVERRUN_CNT_EN
    ,
    output logic [7:0]            overrun_cnt
`endif
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SCAN    = 2'd1;
    localparam logic [1:0] S_RESOLVE = 2'd2;
    localparam logic [1:0] S_OUTPUT  = 2'd3;

    localparam logic [10:0] HALF_11   = 11'(DOODLE_HALF);
    localparam logic [9:0]  REACH_X   = 10'(PLAT_HALF_W + DOODLE_HALF);
    localparam logic [9:0]  SCREEN_10 = 10'(SCREEN_H);
    localparam logic [9:0]  SCROLL_10 = 10'(SCROLL_LINE);
    localparam logic [9:0]  MAX_10    = 10'(MAX_SCROLL);
    localparam logic [2:0]  LAST_IDX  = 3'(N_PLAT - 1);

    logic [1:0]  state_reg;
    logic [2:0]  sync_reg;
    logic [2:0]  idx_reg;
    logic [9:0]  dx_reg, dy_reg, vel_reg;
    logic        found_reg;
    logic [10:0] best_gap_reg;
    logic [2:0]  best_idx_reg;
    logic [9:0]  dist_reg;
    logic [9:0]  plat_x_reg [N_PLAT];
    logic [9:0]  plat_y_reg [N_PLAT];

    // frame_clk is asynchronous: two flops to resolve metastability, third for edge detect
    logic start;
    assign start = sync_reg[1] & ~sync_reg[2];
    assign busy  = (state_reg != S_IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < N_PLAT; gi++) begin : g_snap
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    plat_x_reg[gi] <= '0;
                    plat_y_reg[gi] <= '0;
                end else if (state_reg == S_IDLE && start) begin
                    plat_x_reg[gi] <= Plat_X_all[10*gi +: 10];
                    plat_y_reg[gi] <= Plat_Y_all[10*gi +: 10];
                end
            end
        end
    endgenerate

    logic [9:0]  cur_px, cur_py, dx_abs, dist_next;
    logic [10:0] bottom, py11, gap;
    logic [11:0] reach;
    logic        vel_pos, hit, better;
    logic [16:0] score_sum;

    always_comb begin
        cur_px    = plat_x_reg[idx_reg];
        cur_py    = plat_y_reg[idx_reg];
        vel_pos   = !vel_reg[9] && (vel_reg != 10'd0);
        bottom    = {1'b0, dy_reg} + HALF_11;
        py11      = {1'b0, cur_py};
        reach     = {1'b0, bottom} + {3'b000, vel_reg[8:0]};
        dx_abs    = (dx_reg >= cur_px) ? (dx_reg - cur_px) : (cur_px - dx_reg);
        gap       = py11 - bottom;
        hit       = vel_pos && (cur_py < SCREEN_10) && (bottom <= py11) &&
                    (reach >= {1'b0, py11}) && (dx_abs <= REACH_X);
        // strict compare keeps the lower index on equal gaps
        better    = hit && (!found_reg || gap < best_gap_reg);
        dist_next = 10'd0;
        if (dy_reg < SCROLL_10)
            dist_next = ((SCROLL_10 - dy_reg) > MAX_10) ? MAX_10 : (SCROLL_10 - dy_reg);
        score_sum = {1'b0, score} + {7'd0, dist_reg};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg    <= S_IDLE;
            sync_reg     <= '0;
            idx_reg      <= '0;
            dx_reg       <= '0;
            dy_reg       <= '0;
            vel_reg      <= '0;
            found_reg    <= 1'b0;
            best_gap_reg <= '0;
            best_idx_reg <= '0;
            dist_reg     <= '0;
            land_pulse   <= 1'b0;
            land_idx     <= '0;
            distance     <= '0;
            scroll_valid <= 1'b0;
            score        <= '0;
        end else begin
            sync_reg     <= {sync_reg[1:0], frame_clk};
            land_pulse   <= 1'b0;
            scroll_valid <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        dx_reg    <= Doodle_X;
                        dy_reg    <= Doodle_Y;
                        vel_reg   <= Doodle_Y_vel;
                        found_reg <= 1'b0;
                        idx_reg   <= '0;
                        state_reg <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (better) begin
                        found_reg    <= 1'b1;
                        best_gap_reg <= gap;
                        best_idx_reg <= idx_reg;
                    end
                    idx_reg <= idx_reg + 3'd1;
                    if (idx_reg == LAST_IDX)
                        state_reg <= S_RESOLVE;
                end
                S_RESOLVE: begin
                    dist_reg  <= dist_next;
                    state_reg <= S_OUTPUT;
                end
                default: begin
                    distance     <= dist_reg;
                    scroll_valid <= 1'b1;
                    if (found_reg) begin
                        land_pulse <= 1'b1;
                        land_idx   <= best_idx_reg;
                    end
                    score     <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PLAT_OVERRUN_CNT_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            overrun_cnt <= '0;
        else if (start && busy && overrun_cnt != 8'hFF)
            overrun_cnt <= overrun_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_platform_landing_detect.sv
// Directed bench for platform_landing_detect: landing, tie-break, X boundary, no-scroll, overrun, reset, score saturation.
module tb_platform_landing_detect;
    logic        Clk = 1'b0;
    logic        clk_en = 1'b1;
    logic        Reset_n;
    logic        frame_clk;
    logic [9:0]  Doodle_X, Doodle_Y, Doodle_Y_vel;
    logic [79:0] Plat_X_all, Plat_Y_all;
    logic        land_pulse, scroll_valid, busy;
    logic [2:0]  land_idx;
    logic [9:0]  distance;
    logic [15:0] score;
`ifdef PLAT_OVERRUN_CNT_EN
    logic [7:0]  overrun_cnt;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    platform_landing_detect dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .Doodle_X(Doodle_X), .Doodle_Y(Doodle_Y), .Doodle_Y_vel(Doodle_Y_vel),
        .Plat_X_all(Plat_X_all), .Plat_Y_all(Plat_Y_all),
        .land_pulse(land_pulse), .land_idx(land_idx), .distance(distance),
        .scroll_valid(scroll_valid), .busy(busy), .score(score)
`ifdef PLAT_OVERRUN_CNT_EN
        , .overrun_cnt(overrun_cnt)
`endif
    );

    initial forever begin
        #10;
        if (clk_en) Clk = ~Clk;
    end

    task automatic clear_plats();
        for (int i = 0; i < 8; i++) begin
            Plat_X_all[10*i +: 10] = 10'd0;
            Plat_Y_all[10*i +: 10] = 10'd300;
        end
    endtask

    task automatic set_plat(input int i, input int x, input int y);
        Plat_X_all[10*i +: 10] = 10'(x);
        Plat_Y_all[10*i +: 10] = 10'(y);
    endtask

    task automatic set_doodle(input int x, input int y, input int v);
        Doodle_X = 10'(x);
        Doodle_Y = 10'(y);
        Doodle_Y_vel = 10'(v);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        frame_clk = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    // Raises frame_clk and returns #1 after the edge where scroll_valid appears (lat = posedges counted, -1 on timeout).
    // disturb: rescramble inputs and re-raise frame_clk 3 cycles into SCAN.
    task automatic run_frame(input bit disturb, output int lat);
        lat = -1;
        @(negedge Clk);
        frame_clk = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge Clk);
            #1;
            if (c == 3) frame_clk = 1'b0;
            if (disturb && c == 6) begin
                frame_clk = 1'b1;
                clear_plats();
                set_doodle(0, 200, -1);
            end
            if (scroll_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_cmp++; if (score !== 16'd0) begin n_fail++; $display("FAIL reset_score: got %0d want 0", score); end
        n_cmp++; if (distance !== 10'd0 || land_idx !== 3'd0 || land_pulse !== 1'b0 || scroll_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: dist=%0d idx=%0d lp=%0b sv=%0b want all 0", distance, land_idx, land_pulse, scroll_valid);
        end
        $display("reset: busy=%0b score=%0d dist=%0d", busy, score, distance);
    endtask

    task automatic test_simple_landing();
        int lat;
        do_reset();
        clear_plats();
        set_plat(3, 170, 110);
        set_doodle(160, 100, 5);
        run_frame(1'b0, lat);
        $display("simple: lat=%0d lp=%0b idx=%0d dist=%0d score=%0d", lat, land_pulse, land_idx, distance, score);
        // 3 synchroniser/edge cycles + N_PLAT + 2
        n_cmp++; if (lat !== 13) begin n_fail++; $display("FAIL simple_latency: got %0d want 13", lat); end
        n_cmp++; if (land_pulse !== 1'b1) begin n_fail++; $display("FAIL simple_land_pulse: got %0b want 1", land_pulse); end
        n_cmp++; if (land_idx !== 3'd3) begin n_fail++; $display("FAIL simple_land_idx: got %0d want 3", land_idx); end
        n_cmp++; if (distance !== 10'd15) begin n_fail++; $display("FAIL simple_distance: got %0d want 15", distance); end
        n_cmp++; if (score !== 16'd15) begin n_fail++; $display("FAIL simple_score: got %0d want 15", score); end
        @(posedge Clk); #1;
        n_cmp++; if (land_pulse !== 1'b0 || scroll_valid !== 1'b0) begin
            n_fail++; $display("FAIL simple_pulse_width: lp=%0b sv=%0b want 0 0", land_pulse, scroll_valid);
        end
        n_cmp++; if (land_idx !== 3'd3 || distance !== 10'd15) begin
            n_fail++; $display("FAIL simple_hold: idx=%0d dist=%0d want 3 15", land_idx, distance);
        end
    endtask

    task automatic test_reset_mid_scan();
        // leaves state from test_simple_landing: land_idx=3, distance=15, score=15
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (5) @(posedge Clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midscan_busy_before: got %0b want 1", busy); end
        clk_en = 1'b0;
        #5;
        Reset_n = 1'b0;
        #1;
        $display("reset_mid_scan: busy=%0b idx=%0d dist=%0d score=%0d", busy, land_idx, distance, score);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midscan_busy: got %0b want 0", busy); end
        n_cmp++; if (land_idx !== 3'd0 || distance !== 10'd0 || score !== 16'd0) begin
            n_fail++; $display("FAIL midscan_outputs: idx=%0d dist=%0d score=%0d want 0 0 0", land_idx, distance, score);
        end
        frame_clk = 1'b0;
        #5;
        Reset_n = 1'b1;
        clk_en = 1'b1;
        begin
            int seen = 0;
            for (int c = 0; c < 20; c++) begin
                @(posedge Clk); #1;
                if (scroll_valid || land_pulse) seen++;
            end
            n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL midscan_no_pulse: got %0d pulses want 0", seen); end
        end
    endtask

    task automatic test_tie_nearest();
        int lat;
        do_reset();
        clear_plats();
        set_plat(2, 160, 112);
        set_plat(5, 160, 112);
        set_plat(1, 160, 114);
        set_doodle(160, 102, 6);
        run_frame(1'b0, lat);
        $display("tie: lat=%0d lp=%0b idx=%0d dist=%0d", lat, land_pulse, land_idx, distance);
        n_cmp++; if (land_pulse !== 1'b1 || land_idx !== 3'd2) begin
            n_fail++; $display("FAIL tie_idx: lp=%0b idx=%0d want 1 2", land_pulse, land_idx);
        end
        n_cmp++; if (distance !== 10'd15) begin n_fail++; $display("FAIL tie_distance: got %0d want 15", distance); end
    endtask

    task automatic test_x_edge();
        int lat;
        int xs [3] = '{188, 132, 189};
        bit lp_exp [3] = '{1'b1, 1'b1, 1'b0};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            clear_plats();
            set_plat(0, xs[k], 110);
            set_doodle(160, 100, 5);
            run_frame(1'b0, lat);
            $display("x_edge: plat_x=%0d lat=%0d lp=%0b idx=%0d dist=%0d", xs[k], lat, land_pulse, land_idx, distance);
            n_cmp++; if (land_pulse !== lp_exp[k]) begin
                n_fail++; $display("FAIL x_edge_%0d: land_pulse got %0b want %0b", xs[k], land_pulse, lp_exp[k]);
            end
        end
    endtask

    task automatic test_no_scroll();
        int lat;
        int ys [3]  = '{200, 200, 235};
        int pys [3] = '{210, 210, 245};
        int vs [3]  = '{-4, 0, 5};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            clear_plats();
            set_plat(4, 160, pys[k]);
            set_doodle(160, ys[k], vs[k]);
            run_frame(1'b0, lat);
            $display("no_scroll: y=%0d vel=%0d lat=%0d lp=%0b dist=%0d", ys[k], vs[k], lat, land_pulse, distance);
            n_cmp++; if (lat !== 13) begin n_fail++; $display("FAIL noscroll_valid_%0d: lat got %0d want 13", k, lat); end
            n_cmp++; if (land_pulse !== 1'b0) begin n_fail++; $display("FAIL noscroll_land_%0d: got %0b want 0", k, land_pulse); end
            n_cmp++; if (distance !== 10'd0) begin n_fail++; $display("FAIL noscroll_dist_%0d: got %0d want 0", k, distance); end
        end
        n_cmp++; if (score !== 16'd0) begin n_fail++; $display("FAIL noscroll_score: got %0d want 0", score); end
    endtask

    task automatic test_overrun();
        int lat;
        int extra = 0;
        do_reset();
        clear_plats();
        set_plat(3, 170, 110);
        set_doodle(160, 100, 5);
        run_frame(1'b1, lat);
        $display("overrun: lat=%0d lp=%0b idx=%0d dist=%0d", lat, land_pulse, land_idx, distance);
        n_cmp++; if (lat !== 13 || land_pulse !== 1'b1 || land_idx !== 3'd3) begin
            n_fail++; $display("FAIL overrun_snapshot: lat=%0d lp=%0b idx=%0d want 13 1 3", lat, land_pulse, land_idx);
        end
        n_cmp++; if (distance !== 10'd15) begin n_fail++; $display("FAIL overrun_distance: got %0d want 15", distance); end
        frame_clk = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(posedge Clk); #1;
            if (scroll_valid) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_fail++; $display("FAIL overrun_single_valid: extra pulses %0d want 0", extra); end
`ifdef PLAT_OVERRUN_CNT_EN
        n_cmp++; if (overrun_cnt !== 8'd1) begin n_fail++; $display("FAIL overrun_cnt: got %0d want 1", overrun_cnt); end
`endif
    endtask

    task automatic test_score_saturation();
        int lat;
        int timeouts = 0;
        do_reset();
        clear_plats();
        set_doodle(160, 100, 5);
        // 4369 * 15 = 65535 exactly
        for (int f = 0; f < 4369; f++) begin
            run_frame(1'b0, lat);
            if (lat < 0) timeouts++;
        end
        $display("saturation: after 4369 frames score=%0d", score);
        n_cmp++; if (timeouts !== 0) begin n_fail++; $display("FAIL sat_timeouts: got %0d want 0", timeouts); end
        n_cmp++; if (score !== 16'hFFFF) begin n_fail++; $display("FAIL sat_exact: got %0d want 65535", score); end
        run_frame(1'b0, lat);
        $display("saturation: frame 4370 lat=%0d score=%0d dist=%0d", lat, score, distance);
        n_cmp++; if (lat !== 13 || score !== 16'hFFFF) begin
            n_fail++; $display("FAIL sat_hold: lat=%0d score=%0d want 13 65535", lat, score);
        end
    endtask

    initial begin
        Reset_n = 1'b1;
        frame_clk = 1'b0;
        clear_plats();
        set_doodle(0, 0, 0);
        test_reset();
        test_simple_landing();
        test_reset_mid_scan();
        test_tie_nearest();
        test_x_edge();
        test_no_scroll();
        test_overrun();
        test_score_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/platform_landing_detect.md
Name: platform_landing_detect

Overview:
- Consumer side of the platform coordinate interface. Reads the 8 platform X/Y positions and the doodle position/velocity once per frame.
- Detects a landing on any platform and computes the per-frame scroll `distance` that the platform mover consumes.
- Accumulates a score.
- Sits between the doodle motion block, the platform mover and the score display; runs on Clk and is triggered by frame_clk.

Parameters:
- N_PLAT, 8, number of platforms scanned per frame (index width 3)
- PLAT_HALF_W, 20, platform half-width in pixels
- DOODLE_HALF, 8, doodle half-size in pixels (X and Y)
- SCROLL_LINE, 120, Y threshold; the doodle above this line scrolls the world
- MAX_SCROLL, 15, per-frame scroll saturation value
- SCREEN_H, 240, screen height; Y values >= SCREEN_H are off-screen and never landable

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  asynchronous active-low reset
- frame_clk  in  1  frame tick (~60 Hz), asynchronous to Clk
- Doodle_X  in  10  doodle centre X
- Doodle_Y  in  10  doodle centre Y
- Doodle_Y_vel  in  10  signed Y velocity, positive = falling
- Plat_X_all  in  10*N_PLAT  platform centre X, platform i at bits [10i+9:10i]
- Plat_Y_all  in  10*N_PLAT  platform top Y, same packing
- land_pulse  out  1  one-Clk pulse when a landing is detected this frame
- land_idx  out  3  index of the landed platform, held until the next landing
- distance  out  10  scroll distance for the current frame, held between updates
- scroll_valid  out  1  one-Clk pulse marking a distance update
- busy  out  1  high while the FSM is not IDLE
- score  out  16  accumulated scroll total, saturating

Behaviour:
- Reset (async, Reset_n=0): all outputs 0, FSM IDLE, synchronisers cleared.
- frame_clk passes a 2-FF synchroniser plus a rising-edge detect, producing `start`.
- FSM states: IDLE, SCAN, RESOLVE, OUTPUT.
- IDLE, start=1: snapshot all inputs into registers, clear best-candidate, go to SCAN with idx=0.
- SCAN: evaluate platform idx each cycle; idx increments; after idx=N_PLAT-1 go to RESOLVE. Exactly N_PLAT cycles.
- Hit condition for platform i, all on snapshot values with 11-bit unsigned/signed arithmetic, no wrap:
  - vel > 0
  - Plat_Y[i] < SCREEN_H
  - bottom = Doodle_Y + DOODLE_HALF
  - bottom <= Plat_Y[i] and bottom + vel >= Plat_Y[i]
  - |Doodle_X - Plat_X[i]| <= PLAT_HALF_W + DOODLE_HALF; the boundary is inclusive.
- Candidate selection: the smallest (Plat_Y[i] - bottom) wins; ties go to the lower index.
- RESOLVE:
  - If Doodle_Y < SCROLL_LINE: dist = min(SCROLL_LINE - Doodle_Y, MAX_SCROLL); else dist = 0.
  - Go to OUTPUT.
- OUTPUT (1 cycle):
  - `distance` <= dist and scroll_valid = 1.
  - On a hit: land_pulse = 1 and land_idx updated.
  - score <= score + dist, saturating at 16'hFFFF.
  - Then IDLE.
- Latency: outputs register at the cycle after OUTPUT is entered, i.e. start + N_PLAT + 2 Clk cycles.
- busy is low only in IDLE.
- start while not IDLE is dropped (frame overrun); the current evaluation completes unchanged.
- Input changes after the snapshot have no effect until the next frame.
- Reset mid-scan aborts immediately: no pulses, outputs return to 0.
- Vel <= 0 never lands, including 0 and negative values.

Optional Feature:
- Macro: PLAT_OVERRUN_CNT_EN.
- Defined:
  - Adds an output port `overrun_cnt` [7:0] that counts start events dropped while busy.
  - The counter saturates at 255 and clears only on reset.
- Undefined: the port and counter are absent; overruns are silently dropped.

Test Plan:
- Reset: hold Reset_n=0 mid-SCAN -> all outputs 0 and busy=0 immediately, even with Clk stopped.
- Simple landing:
  - Stimulus: Doodle=(160,100), vel=+5, platform 3 at (170,110), all others Y=300.
  - Response: land_pulse once, land_idx=3, distance=15 (120-100=20 saturated), score=15.
  - Timing: pulses exactly N_PLAT+2 cycles after start.
- Tie and nearest:
  - Platforms 2 and 5 both at (160,112), platform 1 at (160,114); Doodle=(160,102), vel=+6.
  - Response: land_idx=2 and distance=15.
- X edge: platform at X=188, Doodle_X=160 (diff 28) -> hit; platform at X=189 (diff 29) -> no land_pulse.
- Upward/no scroll: vel=-4, Doodle_Y=200, platform directly below -> no land_pulse, distance=0, scroll_valid pulses.
- Overrun (with PLAT_OVERRUN_CNT_EN): second frame_clk edge arrives 3 cycles into SCAN -> a single scroll_valid, overrun_cnt=1. Score saturation: preload via 4370 frames of distance 15 -> score stays 16'hFFFF.
